// File: rtl/time_entry_register_if.sv
// Keypad/countdown-side bundle for the time entry register.
// The slave is the entry register; the master is the keypad/control side.
interface time_entry_register_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       done;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       loadn;
   logic       locked;
   logic       err;
   logic [2:0] ndigits;

   modport master (
      output key_valid, key_code, done,
      input  min_tens, min_ones, sec_tens, sec_ones, loadn, locked, err, ndigits
   );

   modport slave (
      input  key_valid, key_code, done,
      output min_tens, min_ones, sec_tens, sec_ones, loadn, locked, err, ndigits
   );
endinterface

// File: rtl/time_entry_register.sv
// MM:SS keypad entry buffer for the microwave timer. Shifts in BCD digits,
// validates on start, pulses loadn for one cycle, then locks until done/clear.
module time_entry_register #(
   parameter logic [3:0] SEC_TENS_MAX = 4'd5,
   parameter logic [3:0] KEY_CLEAR    = 4'd10,
   parameter logic [3:0] KEY_START    = 4'd11
) (
   input  logic                  clk,
   input  logic                  clr,
   time_entry_register_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ENTRY, LOAD, LOCKED} state_t;

   state_t     state_q,    state_d;
   logic [3:0] min_tens_q, min_tens_d;
   logic [3:0] min_ones_q, min_ones_d;
   logic [3:0] sec_tens_q, sec_tens_d;
   logic [3:0] sec_ones_q, sec_ones_d;
   logic [2:0] ndigits_q,  ndigits_d;
   logic       err_q,      err_d;
   logic       loadn_q,    loadn_d;
   logic       locked_q,   locked_d;

   logic is_digit, is_clear, is_start, all_zero, bad_time;

   assign is_digit = bus.key_valid && (bus.key_code < 4'd10);
   assign is_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);
   assign is_start = bus.key_valid && (bus.key_code == KEY_START);
   assign all_zero = ({min_tens_q, min_ones_q, sec_tens_q, sec_ones_q} == 16'h0000);
   assign bad_time = (sec_tens_q > SEC_TENS_MAX) || all_zero;

   always_comb begin
      state_d    = state_q;
      min_tens_d = min_tens_q;
      min_ones_d = min_ones_q;
      sec_tens_d = sec_tens_q;
      sec_ones_d = sec_ones_q;
      ndigits_d  = ndigits_q;
      err_d      = err_q;

      case (state_q)
         IDLE, ENTRY: begin
            if (is_digit) begin
               err_d = 1'b0;
               if (ndigits_q < 3'd4) begin
                  min_tens_d = min_ones_q;
                  min_ones_d = sec_tens_q;
                  sec_tens_d = sec_ones_q;
                  sec_ones_d = bus.key_code;
                  ndigits_d  = ndigits_q + 3'd1;
                  state_d    = ENTRY;
               end
            end else if (is_clear) begin
               {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} = '0;
               ndigits_d = '0;
               err_d     = 1'b0;
               state_d   = IDLE;
            end else if (is_start) begin
               if (state_q == IDLE || bad_time) err_d = 1'b1;
               else                             state_d = LOAD;
            end
         end
         // Keys during the load cycle are dropped so the counters see stable data.
         LOAD: state_d = LOCKED;
         LOCKED: begin
            if (bus.done || is_clear) begin
               {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} = '0;
               ndigits_d = '0;
               state_d   = IDLE;
               if (!bus.done) err_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      loadn_d  = (state_d != LOAD);
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= IDLE;
         min_tens_q <= '0;
         min_ones_q <= '0;
         sec_tens_q <= '0;
         sec_ones_q <= '0;
         ndigits_q  <= '0;
         err_q      <= 1'b0;
         loadn_q    <= 1'b1;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         min_tens_q <= min_tens_d;
         min_ones_q <= min_ones_d;
         sec_tens_q <= sec_tens_d;
         sec_ones_q <= sec_ones_d;
         ndigits_q  <= ndigits_d;
         err_q      <= err_d;
         loadn_q    <= loadn_d;
         locked_q   <= locked_d;
      end
   end

   assign bus.min_tens = min_tens_q;
   assign bus.min_ones = min_ones_q;
   assign bus.sec_tens = sec_tens_q;
   assign bus.sec_ones = sec_ones_q;
   assign bus.ndigits  = ndigits_q;
   assign bus.err      = err_q;
   assign bus.loadn    = loadn_q;
   assign bus.locked   = locked_q;
endmodule

// File: tb/tb_time_entry_register.sv
// Directed vector bench for time_entry_register: one table row per clock,
// plus hand sequences for reset and clr landing in the load cycle.
module tb_time_entry_register;
   logic clk = 1'b0;
   logic clr;

   time_entry_register_if bus ();

   time_entry_register dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        kv;
      logic [3:0]  code;
      logic        dn;
      logic [15:0] dig;
      logic [2:0]  nd;
      logic        ld;
      logic        lk;
      logic        er;
   } vec_t;

   vec_t tbl[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(input logic kv, input logic [3:0] code, input logic dn,
                               input logic [15:0] dig, input logic [2:0] nd,
                               input logic ld, input logic lk, input logic er);
      vec_t v;
      v.kv = kv; v.code = code; v.dn = dn; v.dig = dig;
      v.nd = nd; v.ld = ld; v.lk = lk; v.er = er;
      return v;
   endfunction

   function automatic logic [21:0] observed();
      return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
              bus.ndigits, bus.loadn, bus.locked, bus.err};
   endfunction

   task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got dig=%h nd=%0d loadn=%b locked=%b err=%b, expected dig=%h nd=%0d loadn=%b locked=%b err=%b",
                  name, act[21:6], act[5:3], act[2], act[1], act[0],
                  exp[21:6], exp[5:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic step(input logic kv, input logic [3:0] code, input logic dn);
      @(negedge clk);
      bus.key_valid = kv;
      bus.key_code  = code;
      bus.done      = dn;
      @(posedge clk);
      #1;
   endtask

   localparam logic [21:0] RESET_VAL = {16'h0000, 3'd0, 1'b1, 1'b0, 1'b0};

   initial begin
      // Enter 1,3,4,5 and start; keys while locked ignored; done unlocks
      tbl.push_back(mk(1, 4'd1,  0, 16'h0001, 3'd1, 1, 0, 0));
      tbl.push_back(mk(1, 4'd3,  0, 16'h0013, 3'd2, 1, 0, 0));
      tbl.push_back(mk(1, 4'd4,  0, 16'h0134, 3'd3, 1, 0, 0));
      tbl.push_back(mk(1, 4'd5,  0, 16'h1345, 3'd4, 1, 0, 0));
      tbl.push_back(mk(1, 4'd11, 0, 16'h1345, 3'd4, 0, 0, 0));
      tbl.push_back(mk(0, 4'd0,  0, 16'h1345, 3'd4, 1, 1, 0));
      tbl.push_back(mk(1, 4'd8,  0, 16'h1345, 3'd4, 1, 1, 0));
      tbl.push_back(mk(1, 4'd11, 0, 16'h1345, 3'd4, 1, 1, 0));
      tbl.push_back(mk(0, 4'd0,  1, 16'h0000, 3'd0, 1, 0, 0));
      // Start from IDLE rejected; 7,0 rejected on sec_tens; digit clears err
      tbl.push_back(mk(1, 4'd11, 0, 16'h0000, 3'd0, 1, 0, 1));
      tbl.push_back(mk(1, 4'd7,  0, 16'h0007, 3'd1, 1, 0, 0));
      tbl.push_back(mk(1, 4'd0,  0, 16'h0070, 3'd2, 1, 0, 0));
      tbl.push_back(mk(1, 4'd11, 0, 16'h0070, 3'd2, 1, 0, 1));
      tbl.push_back(mk(1, 4'd2,  0, 16'h0702, 3'd3, 1, 0, 0));
      tbl.push_back(mk(1, 4'd10, 0, 16'h0000, 3'd0, 1, 0, 0));
      // Fifth digit ignored
      tbl.push_back(mk(1, 4'd1,  0, 16'h0001, 3'd1, 1, 0, 0));
      tbl.push_back(mk(1, 4'd2,  0, 16'h0012, 3'd2, 1, 0, 0));
      tbl.push_back(mk(1, 4'd3,  0, 16'h0123, 3'd3, 1, 0, 0));
      tbl.push_back(mk(1, 4'd4,  0, 16'h1234, 3'd4, 1, 0, 0));
      tbl.push_back(mk(1, 4'd9,  0, 16'h1234, 3'd4, 1, 0, 0));
      tbl.push_back(mk(1, 4'd10, 0, 16'h0000, 3'd0, 1, 0, 0));
      // 0,0,0,0 start rejected; invalid code leaves err; clear drops it
      tbl.push_back(mk(1, 4'd0,  0, 16'h0000, 3'd1, 1, 0, 0));
      tbl.push_back(mk(1, 4'd0,  0, 16'h0000, 3'd2, 1, 0, 0));
      tbl.push_back(mk(1, 4'd0,  0, 16'h0000, 3'd3, 1, 0, 0));
      tbl.push_back(mk(1, 4'd0,  0, 16'h0000, 3'd4, 1, 0, 0));
      tbl.push_back(mk(1, 4'd11, 0, 16'h0000, 3'd4, 1, 0, 1));
      tbl.push_back(mk(1, 4'd14, 0, 16'h0000, 3'd4, 1, 0, 1));
      tbl.push_back(mk(1, 4'd10, 0, 16'h0000, 3'd0, 1, 0, 0));
      // Load 0,0,3,0; key during LOAD dropped; done+key together in LOCKED
      tbl.push_back(mk(1, 4'd0,  0, 16'h0000, 3'd1, 1, 0, 0));
      tbl.push_back(mk(1, 4'd0,  0, 16'h0000, 3'd2, 1, 0, 0));
      tbl.push_back(mk(1, 4'd3,  0, 16'h0003, 3'd3, 1, 0, 0));
      tbl.push_back(mk(1, 4'd0,  0, 16'h0030, 3'd4, 1, 0, 0));
      tbl.push_back(mk(1, 4'd11, 0, 16'h0030, 3'd4, 0, 0, 0));
      tbl.push_back(mk(1, 4'd5,  0, 16'h0030, 3'd4, 1, 1, 0));
      tbl.push_back(mk(1, 4'd8,  0, 16'h0030, 3'd4, 1, 1, 0));
      tbl.push_back(mk(1, 4'd3,  1, 16'h0000, 3'd0, 1, 0, 0));
      tbl.push_back(mk(1, 4'd4,  0, 16'h0004, 3'd1, 1, 0, 0));
      tbl.push_back(mk(1, 4'd10, 0, 16'h0000, 3'd0, 1, 0, 0));
      // sec_tens == 5 boundary accepted; clear while locked
      tbl.push_back(mk(1, 4'd5,  0, 16'h0005, 3'd1, 1, 0, 0));
      tbl.push_back(mk(1, 4'd9,  0, 16'h0059, 3'd2, 1, 0, 0));
      tbl.push_back(mk(1, 4'd11, 0, 16'h0059, 3'd2, 0, 0, 0));
      tbl.push_back(mk(0, 4'd0,  0, 16'h0059, 3'd2, 1, 1, 0));
      tbl.push_back(mk(1, 4'd10, 0, 16'h0000, 3'd0, 1, 0, 0));

      bus.key_valid = 1'b0;
      bus.key_code  = 4'd0;
      bus.done      = 1'b0;
      clr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset", observed(), RESET_VAL);
      @(negedge clk);
      clr = 1'b0;

      foreach (tbl[i]) begin
         step(tbl[i].kv, tbl[i].code, tbl[i].dn);
         check($sformatf("vec%0d", i), observed(),
               {tbl[i].dig, tbl[i].nd, tbl[i].ld, tbl[i].lk, tbl[i].er});
      end

      // clr landing in the LOAD cycle aborts the load
      step(1, 4'd6, 0);
      step(1, 4'd11, 0);
      check("load_before_clr", observed(), {16'h0006, 3'd1, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      bus.key_valid = 1'b0;
      clr = 1'b1;
      @(posedge clk);
      #1;
      check("clr_in_load", observed(), RESET_VAL);
      @(negedge clk);
      clr = 1'b0;
      step(0, 4'd0, 0);
      check("after_clr_idle", observed(), RESET_VAL);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
